// File: rtl/exc_commit_ctrl.sv
// Exception/ertn commit sequencer at the WB boundary: prioritises the cause, pulses the CSR
// block, flushes the pipe and performs a held redirect handshake with pre-IF.
module exc_commit_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [PC_W-1:0]   wb_pc,
    input  logic              wb_int,
    input  logic              wb_adef,
    input  logic              wb_ine,
    input  logic              wb_sys,
    input  logic              wb_brk,
    input  logic              wb_ale,
    input  logic              wb_ertn,
    input  logic [31:0]       ex_entry,
    input  logic [31:0]       ertn_pc,
    output logic              csr_wb_ex,
    output logic [5:0]        csr_ecode,
    output logic [8:0]        csr_esubcode,
    output logic [PC_W-1:0]   csr_wb_pc,
    output logic              csr_ertn_flush,
    output logic              pipe_flush,
    output logic              busy,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    input  logic              redirect_ready,
    output logic [CNT_W-1:0]  ex_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    function automatic logic [5:0] cause_ecode(
        input logic f_int, input logic f_adef, input logic f_ine,
        input logic f_sys, input logic f_brk, input logic f_ale
    );
        logic [5:0] code;
        if (f_int)       code = ECODE_INT;
        else if (f_adef) code = ECODE_ADEF;
        else if (f_ine)  code = ECODE_INE;
        else if (f_sys)  code = ECODE_SYS;
        else if (f_brk)  code = ECODE_BRK;
        else if (f_ale)  code = ECODE_ALE;
        else             code = 6'h00;
        return code;
    endfunction

    state_t             state_r, state_s;
    logic               kind_ex_r, kind_ex_s;
    logic               any_ex_s, event_s;
    logic               wb_ex_s, ertn_flush_s, flush_s, busy_s, rvalid_s;
    logic [5:0]         ecode_s;
    logic [8:0]         esubcode_s;
    logic [PC_W-1:0]    wb_pc_s;
    logic [31:0]        rpc_s;
    logic [CNT_W-1:0]   count_s;

    assign any_ex_s = wb_int | wb_adef | wb_ine | wb_sys | wb_brk | wb_ale;
    assign event_s  = wb_valid & (any_ex_s | wb_ertn);

    // Next-state and next-output computation; all outputs are registered below.
    always_comb begin
        state_s      = state_r;
        kind_ex_s    = kind_ex_r;
        wb_ex_s      = 1'b0;
        ertn_flush_s = 1'b0;
        ecode_s      = csr_ecode;
        esubcode_s   = csr_esubcode;
        wb_pc_s      = csr_wb_pc;
        flush_s      = pipe_flush;
        busy_s       = busy;
        rvalid_s     = redirect_valid;
        rpc_s        = redirect_pc;
        count_s      = ex_count;
        case (state_r)
            ST_IDLE: begin
                flush_s  = 1'b0;
                busy_s   = 1'b0;
                rvalid_s = 1'b0;
                if (event_s) begin
                    state_s      = ST_COMMIT;
                    kind_ex_s    = any_ex_s;
                    wb_ex_s      = any_ex_s;
                    ertn_flush_s = ~any_ex_s;
                    ecode_s      = any_ex_s ? cause_ecode(wb_int, wb_adef, wb_ine, wb_sys, wb_brk, wb_ale)
                                            : 6'h00;
                    esubcode_s   = 9'h000;
                    wb_pc_s      = wb_pc;
                    flush_s      = 1'b1;
                    busy_s       = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                // The target is sampled here so it is already stable on the first REDIRECT cycle.
                state_s  = ST_REDIRECT;
                rvalid_s = 1'b1;
                rpc_s    = kind_ex_r ? ex_entry : ertn_pc;
                if (kind_ex_r) begin
                    count_s = ex_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    count_s = ex_count;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_s  = ST_IDLE;
                    rvalid_s = 1'b0;
                    flush_s  = 1'b0;
                    busy_s   = 1'b0;
                end else begin
                    state_s = ST_REDIRECT;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                rvalid_s = 1'b0;
                flush_s  = 1'b0;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            kind_ex_r      <= 1'b0;
            csr_wb_ex      <= 1'b0;
            csr_ertn_flush <= 1'b0;
            csr_ecode      <= 6'h00;
            csr_esubcode   <= 9'h000;
            csr_wb_pc      <= {PC_W{1'b0}};
            pipe_flush     <= 1'b0;
            busy           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0000_0000;
            ex_count       <= {CNT_W{1'b0}};
        end else begin
            state_r        <= state_s;
            kind_ex_r      <= kind_ex_s;
            csr_wb_ex      <= wb_ex_s;
            csr_ertn_flush <= ertn_flush_s;
            csr_ecode      <= ecode_s;
            csr_esubcode   <= esubcode_s;
            csr_wb_pc      <= wb_pc_s;
            pipe_flush     <= flush_s;
            busy           <= busy_s;
            redirect_valid <= rvalid_s;
            redirect_pc    <= rpc_s;
            ex_count       <= count_s;
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl; CNT_W=4 so that counter wrap is reachable.
module tb_exc_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_int, wb_adef, wb_ine, wb_sys, wb_brk, wb_ale, wb_ertn;
    logic [31:0] wb_pc, ex_entry, ertn_pc;
    logic        csr_wb_ex, csr_ertn_flush, pipe_flush, busy, redirect_valid, redirect_ready;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_wb_pc, redirect_pc;
    logic [3:0]  ex_count;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_cnt;

    exc_commit_ctrl #(.PC_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_int(wb_int), .wb_adef(wb_adef), .wb_ine(wb_ine),
        .wb_sys(wb_sys), .wb_brk(wb_brk), .wb_ale(wb_ale), .wb_ertn(wb_ertn),
        .ex_entry(ex_entry), .ertn_pc(ertn_pc),
        .csr_wb_ex(csr_wb_ex), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .csr_wb_pc(csr_wb_pc), .csr_ertn_flush(csr_ertn_flush),
        .pipe_flush(pipe_flush), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .ex_count(ex_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags = {int, adef, ine, sys, brk, ale, ertn}; presents one event and advances to T+1
    task automatic fire(input logic [6:0] flags, input logic [31:0] pc);
        wb_valid = 1'b1;
        {wb_int, wb_adef, wb_ine, wb_sys, wb_brk, wb_ale, wb_ertn} = flags;
        wb_pc = pc;
        tick();
        wb_valid = 1'b0;
        {wb_int, wb_adef, wb_ine, wb_sys, wb_brk, wb_ale, wb_ertn} = 7'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({csr_wb_ex, csr_ertn_flush, pipe_flush, busy, redirect_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000",
                {csr_wb_ex, csr_ertn_flush, pipe_flush, busy, redirect_valid});
        end
        checks++;
        if ({csr_ecode, csr_esubcode, csr_wb_pc, redirect_pc, ex_count} !== 83'd0) begin
            errors++; $display("FAIL reset_data: ecode=%h esub=%h wbpc=%h rpc=%h cnt=%h expected all 0",
                csr_ecode, csr_esubcode, csr_wb_pc, redirect_pc, ex_count);
        end
        rst = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_syscall();
        ex_entry = 32'h1C00_8000;
        redirect_ready = 1'b1;
        fire(7'b0001000, 32'h1C00_0100);
        checks++;
        if ({csr_wb_ex, csr_ertn_flush, pipe_flush, busy} !== 4'b1011) begin
            errors++; $display("FAIL sys_t1_flags: got %b expected 1011",
                {csr_wb_ex, csr_ertn_flush, pipe_flush, busy});
        end
        checks++;
        if (csr_ecode !== 6'h0B || csr_esubcode !== 9'h000) begin
            errors++; $display("FAIL sys_ecode: got %h/%h expected 0b/000", csr_ecode, csr_esubcode);
        end
        checks++;
        if (csr_wb_pc !== 32'h1C00_0100) begin
            errors++; $display("FAIL sys_wb_pc: got %h expected 1c000100", csr_wb_pc);
        end
        tick();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_8000 || csr_wb_ex !== 1'b0) begin
            errors++; $display("FAIL sys_t2_redirect: valid=%b pc=%h wbex=%b expected 1/1c008000/0",
                redirect_valid, redirect_pc, csr_wb_ex);
        end
        tick();
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (busy !== 1'b0 || redirect_valid !== 1'b0 || pipe_flush !== 1'b0 || ex_count !== exp_cnt) begin
            errors++; $display("FAIL sys_t3_idle: busy=%b rv=%b flush=%b cnt=%0d expected 0/0/0/%0d",
                busy, redirect_valid, pipe_flush, ex_count, exp_cnt);
        end
    endtask

    task automatic test_priority();
        logic [6:0] flags [6];
        logic [5:0] codes [6];
        flags[0] = 7'b1010010; codes[0] = 6'h00;
        flags[1] = 7'b0101000; codes[1] = 6'h08;
        flags[2] = 7'b0000110; codes[2] = 6'h0C;
        flags[3] = 7'b0011000; codes[3] = 6'h0D;
        flags[4] = 7'b0000010; codes[4] = 6'h09;
        flags[5] = 7'b1111111; codes[5] = 6'h00;
        redirect_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fire(flags[i], 32'h1C00_0200 + 32'(i * 4));
            checks++;
            if (csr_wb_ex !== 1'b1 || csr_ecode !== codes[i]) begin
                errors++; $display("FAIL prio_%0d: wbex=%b ecode=%h expected 1/%h",
                    i, csr_wb_ex, csr_ecode, codes[i]);
            end
            exp_cnt = exp_cnt + 4'd1;
            tick();
            tick();
        end
        checks++;
        if (ex_count !== exp_cnt) begin
            errors++; $display("FAIL prio_count: got %0d expected %0d", ex_count, exp_cnt);
        end
    endtask

    task automatic test_ertn();
        ertn_pc = 32'h1C00_0104;
        redirect_ready = 1'b1;
        fire(7'b0000001, 32'h1C00_0300);
        checks++;
        if (csr_ertn_flush !== 1'b1 || csr_wb_ex !== 1'b0 || pipe_flush !== 1'b1) begin
            errors++; $display("FAIL ertn_t1: ertn=%b wbex=%b flush=%b expected 1/0/1",
                csr_ertn_flush, csr_wb_ex, pipe_flush);
        end
        tick();
        checks++;
        if (redirect_pc !== 32'h1C00_0104 || redirect_valid !== 1'b1 || csr_ertn_flush !== 1'b0) begin
            errors++; $display("FAIL ertn_t2: pc=%h rv=%b ertn=%b expected 1c000104/1/0",
                redirect_pc, redirect_valid, csr_ertn_flush);
        end
        tick();
        checks++;
        if (ex_count !== exp_cnt) begin
            errors++; $display("FAIL ertn_count: got %0d expected %0d", ex_count, exp_cnt);
        end
        fire(7'b0000011, 32'h1C00_0400);
        checks++;
        if (csr_wb_ex !== 1'b1 || csr_ertn_flush !== 1'b0 || csr_ecode !== 6'h09) begin
            errors++; $display("FAIL ertn_ale: wbex=%b ertn=%b ecode=%h expected 1/0/09",
                csr_wb_ex, csr_ertn_flush, csr_ecode);
        end
        tick();
        checks++;
        if (redirect_pc !== ex_entry) begin
            errors++; $display("FAIL ertn_ale_target: got %h expected %h", redirect_pc, ex_entry);
        end
        tick();
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (ex_count !== exp_cnt) begin
            errors++; $display("FAIL ertn_ale_count: got %0d expected %0d", ex_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        ex_entry = 32'h1C00_9000;
        redirect_ready = 1'b0;
        fire(7'b0000100, 32'h1C00_0500);
        exp_cnt = exp_cnt + 4'd1;
        tick();
        ex_entry = 32'h1C00_A000;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                wb_valid = 1'b1; wb_brk = 1'b1;
            end
            if (i == 3) begin
                wb_valid = 1'b0; wb_brk = 1'b0;
            end
            checks++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_9000 || busy !== 1'b1 ||
                csr_wb_ex !== 1'b0 || ex_count !== exp_cnt) begin
                errors++; $display("FAIL bp_hold_%0d: rv=%b pc=%h busy=%b wbex=%b cnt=%0d expected 1/1c009000/1/0/%0d",
                    i, redirect_valid, redirect_pc, busy, csr_wb_ex, ex_count, exp_cnt);
            end
            if (i == 4) redirect_ready = 1'b1;
            tick();
        end
        checks++;
        if (redirect_valid !== 1'b0 || busy !== 1'b0 || pipe_flush !== 1'b0) begin
            errors++; $display("FAIL bp_release: rv=%b busy=%b flush=%b expected 0/0/0",
                redirect_valid, busy, pipe_flush);
        end
        tick();
        checks++;
        if (csr_wb_ex !== 1'b0 || ex_count !== exp_cnt) begin
            errors++; $display("FAIL bp_ignored: wbex=%b cnt=%0d expected 0/%0d", csr_wb_ex, ex_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        redirect_ready = 1'b1;
        fire(7'b0001000, 32'h1C00_0600);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({csr_wb_ex, csr_ertn_flush, pipe_flush, busy, redirect_valid} !== 5'b0 ||
            ex_count !== 4'd0 || csr_ecode !== 6'h00 || csr_wb_pc !== 32'h0 || redirect_pc !== 32'h0) begin
            errors++; $display("FAIL rst_commit: flags=%b cnt=%0d ecode=%h wbpc=%h rpc=%h expected all 0",
                {csr_wb_ex, csr_ertn_flush, pipe_flush, busy, redirect_valid}, ex_count, csr_ecode,
                csr_wb_pc, redirect_pc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({csr_wb_ex, csr_ertn_flush, redirect_valid, busy} !== 4'b0) begin
                errors++; $display("FAIL rst_commit_quiet_%0d: got %b expected 0000", i,
                    {csr_wb_ex, csr_ertn_flush, redirect_valid, busy});
            end
        end
        redirect_ready = 1'b0;
        fire(7'b0000001, 32'h1C00_0700);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        redirect_ready = 1'b1;
        checks++;
        if ({csr_wb_ex, csr_ertn_flush, pipe_flush, busy, redirect_valid} !== 5'b0 ||
            ex_count !== 4'd0 || redirect_pc !== 32'h0) begin
            errors++; $display("FAIL rst_redirect: flags=%b cnt=%0d rpc=%h expected 0/0/0",
                {csr_wb_ex, csr_ertn_flush, pipe_flush, busy, redirect_valid}, ex_count, redirect_pc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({csr_wb_ex, csr_ertn_flush, redirect_valid, busy} !== 4'b0) begin
                errors++; $display("FAIL rst_redirect_quiet_%0d: got %b expected 0000", i,
                    {csr_wb_ex, csr_ertn_flush, redirect_valid, busy});
            end
        end
        exp_cnt = 4'd0;
    endtask

    task automatic test_back_to_back_wrap();
        redirect_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fire(7'b0001000, 32'h1C00_1000 + 32'(i * 4));
            checks++;
            if (csr_wb_ex !== 1'b1) begin
                errors++; $display("FAIL b2b_pulse_%0d: got %b expected 1", i, csr_wb_ex);
            end
            tick();
            exp_cnt = exp_cnt + 4'd1;
            checks++;
            if (csr_wb_ex !== 1'b0 || ex_count !== exp_cnt) begin
                errors++; $display("FAIL b2b_t2_%0d: wbex=%b cnt=%0d expected 0/%0d",
                    i, csr_wb_ex, ex_count, exp_cnt);
            end
            tick();
        end
        checks++;
        if (ex_count !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL wrap_final: cnt=%0d busy=%b expected 0/0", ex_count, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 1'b0;
        {wb_int, wb_adef, wb_ine, wb_sys, wb_brk, wb_ale, wb_ertn} = 7'b0;
        wb_pc = 32'h0;
        ex_entry = 32'h1C00_8000;
        ertn_pc = 32'h0;
        redirect_ready = 1'b1;
        exp_cnt = 4'd0;
        test_reset();
        test_syscall();
        test_priority();
        test_ertn();
        test_backpressure();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Exception/return sequencer at the WB boundary of the single-issue LoongArch pipeline.
- Collects the per-instruction exception flags and ertn marker of the instruction in WB, and prioritises them into one ecode/esubcode.
- Drives the CSR block's wb_ex / ertn_flush pulses, flushes the pipeline, then performs a held redirect handshake with pre-IF to ex_entry or ertn_pc.
- Keeps a free-running count of taken exceptions.

Parameters:
- PC_W, 32, program counter width
- CNT_W, 32, width of exception statistics counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- wb_valid  input  1  valid instruction in WB this cycle
- wb_pc  input  PC_W  PC of WB instruction
- wb_int  input  1  interrupt tagged onto this instruction in ID
- wb_adef  input  1  fetch address error
- wb_ine  input  1  instruction not exist
- wb_sys  input  1  syscall
- wb_brk  input  1  break
- wb_ale  input  1  memory address misaligned
- wb_ertn  input  1  instruction is ertn
- ex_entry  input  32  exception entry from CSR block
- ertn_pc  input  32  return address from CSR block
- csr_wb_ex  output  1  one-cycle exception commit pulse to CSR block
- csr_ecode  output  6  ecode to CSR block
- csr_esubcode  output  9  esubcode to CSR block
- csr_wb_pc  output  PC_W  faulting PC to CSR block
- csr_ertn_flush  output  1  one-cycle ertn commit pulse to CSR block
- pipe_flush  output  1  cancel all instructions in IF..WB
- busy  output  1  controller not idle; WB must not commit
- redirect_valid  output  1  redirect request to pre-IF
- redirect_pc  output  32  redirect target
- redirect_ready  input  1  pre-IF accepts redirect
- ex_count  output  CNT_W  number of exceptions taken

Behaviour:
- Reset (sync): state IDLE. All outputs 0, including ex_count, csr_ecode, csr_esubcode, csr_wb_pc and redirect_pc. A reset asserted in any state aborts the sequence; no pulse is issued afterwards.
- Event detection, IDLE only: event = wb_valid & (any_ex | wb_ertn), where any_ex = OR of the six exception flags. Any event must be detected.
- Inputs are ignored in every non-IDLE state. WB holds its instruction while busy; the instruction is dropped by pipe_flush.
- Priority, highest first, with ecode and esubcode:
  - INT: ecode 0x00
  - ADEF: ecode 0x08, esubcode 0
  - INE: ecode 0x0D
  - SYS: ecode 0x0B
  - BRK: ecode 0x0C
  - ALE: ecode 0x09
  - esubcode is 0 for every cause.
- Exception beats ertn. ertn with no exception flag is a return event.
- States: IDLE -> COMMIT -> REDIRECT -> IDLE.
- Cycle T: event detected in IDLE.
  - Register ecode, esubcode and wb_pc.
  - Register the kind (ex or ret).
  - Next state COMMIT.
- Cycle T+1, COMMIT:
  - csr_wb_ex=1 (ex) or csr_ertn_flush=1 (ret), for exactly one cycle.
  - csr_ecode, csr_esubcode and csr_wb_pc are valid this cycle and hold until the next event.
  - pipe_flush=1 and busy=1.
  - ex_count increments at the end of T+1 for ex only, wrapping modulo 2^CNT_W.
  - Next state REDIRECT.
- Cycle T+2 onward, REDIRECT:
  - redirect_pc is captured on entry from ex_entry (ex) or ertn_pc (ret). The CSR block has updated by then.
  - redirect_valid=1 and redirect_pc are held stable until redirect_ready=1.
  - pipe_flush=1 and busy=1 throughout.
  - On the cycle redirect_ready=1 (handshake), the next state is IDLE. redirect_valid, pipe_flush and busy deassert the following cycle.
  - Changes to ex_entry/ertn_pc while waiting do not alter the held redirect_pc.
- redirect_ready sampled outside REDIRECT has no effect.
- Minimum event-to-event spacing: 3 cycles when redirect_ready is tied high. A new event may be detected in the first IDLE cycle.
- csr_wb_ex and csr_ertn_flush are never high in the same cycle.

Test Plan:
- Syscall: wb_valid=1, wb_sys=1, wb_pc=0x1C000100, ex_entry=0x1C008000, ready=1.
  - T+1: csr_wb_ex=1, csr_ecode=0x0B, csr_wb_pc=0x1C000100, pipe_flush=1.
  - T+2: redirect_valid=1, redirect_pc=0x1C008000.
  - T+3: busy=0; ex_count=1.
- Priority: wb_int=1 with wb_ine=1 and wb_ale=1 -> csr_ecode=0x00.
  - Then wb_adef=1 with wb_sys=1 -> 0x08.
  - Then wb_brk=1 with wb_ale=1 -> 0x0C.
- ertn: wb_ertn=1, ertn_pc=0x1C000104.
  - T+1: csr_ertn_flush=1, csr_wb_ex=0.
  - T+2: redirect_pc=0x1C000104.
  - ex_count unchanged.
  - Repeat with wb_ertn=1 and wb_ale=1 -> exception path, ecode 0x09.
- Backpressure: redirect_ready=0 for 5 cycles.
  - redirect_valid and redirect_pc held for 5 cycles.
  - A wb_valid=1, wb_brk=1 during the wait is ignored.
  - Returns to IDLE one cycle after ready=1.
- Reset mid-sequence: rst in COMMIT, and separately in REDIRECT.
  - Next cycle: every output 0, state IDLE, ex_count=0.
  - No further pulses.
- Counter wrap: CNT_W=4, 16 back-to-back exceptions with ready tied high.
  - ex_count returns to 0.
  - Event spacing is 3 cycles.
